step_activity_monitor: RTL

//  Downstream consumer of the step counter's 16-bit running stepCount. Runs in the system clock domain.

---
 rtl/step_activity_monitor.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/step_activity_monitor.sv
// Step activity monitor: turns the step counter's running total into a
// per-second step rate, distance in half-miles, an early-window count of
// brisk seconds, and accumulated high-activity time.
module step_activity_monitor #(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned HALF_MI_SHIFT = 10,
  parameter int unsigned HI_RATE       = 32,
  parameter int unsigned WINDOW_SEC    = 9,
  parameter int unsigned HA_RATE       = 64,
  parameter int unsigned HA_MIN_SEC    = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startCount,
  input  logic [15:0] stepCount,
  output logic [15:0] stepRate,
  output logic [15:0] distance,
  output logic [3:0]  secOverThresh,
  output logic [15:0] highActTime,
  output logic        secTick
);

  localparam int unsigned DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  // run only has to hold 0..HA_MIN_SEC-1; the crediting second leaves CAND
  localparam int unsigned RUN_W = (HA_MIN_SEC > 1) ? $clog2(HA_MIN_SEC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_HZ - 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(HA_MIN_SEC - 1);
  localparam logic [15:0]      HI_RATE_V = 16'(HI_RATE);
  localparam logic [15:0]      WINDOW_V  = 16'(WINDOW_SEC);
  localparam logic [16:0]      HA_RATE_V = 17'(HA_RATE);
  localparam logic [16:0]      HA_MIN_V  = 17'(HA_MIN_SEC);

  typedef enum logic [1:0] {
    HA_IDLE,
    HA_CAND,
    HA_ACTIVE
  } ha_state_t;

  logic [15:0]      s1;
  logic [15:0]      s2;
  logic [15:0]      stable_count;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             stage2_q;
  logic             sec_tick_q;
  logic [15:0]      step_rate_q;
  logic [15:0]      prev_count_q;
  logic [15:0]      sec_idx_q;
  logic [3:0]       sec_over_q;
  ha_state_t        ha_q;
  ha_state_t        ha_d;
  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_d;
  logic [15:0]      hat_q;
  logic [15:0]      hat_d;
  logic             is_ha;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + b;
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign tick = (div_q == DIV_LAST);
  // rate + 1 > HA_RATE is rate >= HA_RATE, kept as a live compare for HA_RATE = 0
  assign is_ha = (({1'b0, step_rate_q} + 17'd1) > HA_RATE_V);

  // Two-flop synchroniser; only a value seen identically on both flops is trusted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1           <= '0;
      s2           <= '0;
      stable_count <= '0;
    end else if (!startCount) begin
      s1           <= '0;
      s2           <= '0;
      stable_count <= '0;
    end else begin
      s1 <= stepCount;
      s2 <= s1;
      if (s2 == s1) begin
        stable_count <= s2;
      end
    end
  end

  // One-second divider and the two-stage pipeline flags that follow a tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      stage2_q   <= 1'b0;
      sec_tick_q <= 1'b0;
    end else if (!startCount) begin
      div_q      <= '0;
      stage2_q   <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      div_q      <= tick ? '0 : div_q + 1'b1;
      stage2_q   <= tick;
      sec_tick_q <= stage2_q;
    end
  end

  // Stage 1: capture the last second's rate and advance the elapsed-second count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_rate_q  <= '0;
      prev_count_q <= '0;
      sec_idx_q    <= '0;
    end else if (!startCount) begin
      step_rate_q  <= '0;
      prev_count_q <= '0;
      sec_idx_q    <= '0;
    end else if (tick) begin
      step_rate_q  <= stable_count - prev_count_q;
      prev_count_q <= stable_count;
      if (sec_idx_q != 16'hFFFF) begin
        sec_idx_q <= sec_idx_q + 16'd1;
      end
    end
  end

  // Stage 2: count brisk seconds inside the opening window, frozen afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_over_q <= '0;
    end else if (!startCount) begin
      sec_over_q <= '0;
    end else if (stage2_q && (sec_idx_q <= WINDOW_V) && (step_rate_q > HI_RATE_V)) begin
      sec_over_q <= sec_over_q + 4'd1;
    end
  end

  // High-activity FSM state, run length and credited time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ha_q  <= HA_IDLE;
      run_q <= '0;
      hat_q <= '0;
    end else if (!startCount) begin
      ha_q  <= HA_IDLE;
      run_q <= '0;
      hat_q <= '0;
    end else begin
      ha_q  <= ha_d;
      run_q <= run_d;
      hat_q <= hat_d;
    end
  end

  // High-activity next state: a run earns credit only once it reaches HA_MIN_SEC
  always_comb begin
    ha_d  = ha_q;
    run_d = run_q;
    hat_d = hat_q;
    if (stage2_q) begin
      unique case (ha_q)
        HA_IDLE: begin
          if (is_ha) begin
            if (HA_MIN_SEC <= 1) begin
              hat_d = sat_add(hat_q, HA_MIN_V);
              run_d = '0;
              ha_d  = HA_ACTIVE;
            end else begin
              run_d = RUN_W'(1);
              ha_d  = HA_CAND;
            end
          end
        end
        HA_CAND: begin
          if (is_ha) begin
            if (run_q == RUN_LAST) begin
              hat_d = sat_add(hat_q, HA_MIN_V);
              run_d = '0;
              ha_d  = HA_ACTIVE;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
            ha_d  = HA_IDLE;
          end
        end
        HA_ACTIVE: begin
          if (is_ha) begin
            hat_d = sat_add(hat_q, 17'd1);
          end else begin
            ha_d = HA_IDLE;
          end
        end
        default: begin
          run_d = '0;
          ha_d  = HA_IDLE;
        end
      endcase
    end
  end

  assign stepRate      = step_rate_q;
  assign distance      = stable_count >> HALF_MI_SHIFT;
  assign secOverThresh = sec_over_q;
  assign highActTime   = hat_q;
  assign secTick       = sec_tick_q;

endmodule
